// File: rtl/equiv_monitor.sv
// Equivalence monitor: compares two implementation outputs cycle by cycle.
// y_a is aligned to y_b through a SKEW-deep delay line that advances only on en.
// Bits set in mask are ignored. Mismatches are counted, flagged and the first one
// is captured. A warm-up window after reset suppresses comparison.
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - synchronous active-low reset
//   en           - sample-valid qualifier
//   clear        - clears statistics, recovers from FAIL
//   y_a, y_b     - compared buses (y_a is delayed by SKEW enabled samples)
//   mask         - 1 excludes a bit from comparison
//   mismatch     - registered one-cycle pulse per mismatch
//   sticky_err   - set on first mismatch, held until clear/reset
//   mismatch_cnt - saturating mismatch counter
//   first_idx    - sample index of the first mismatch
//   first_diff   - masked XOR captured at the first mismatch
//   state        - 0 warm-up, 1 compare, 2 fail
module equiv_monitor #(
  parameter int unsigned WIDTH        = 91,
  parameter int unsigned SKEW         = 0,
  parameter int unsigned WARMUP       = 4,
  parameter int unsigned CNT_W        = 16,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] y_a,
  input  logic [WIDTH-1:0] y_b,
  input  logic [WIDTH-1:0] mask,
  output logic             mismatch,
  output logic             sticky_err,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [31:0]      first_idx,
  output logic [WIDTH-1:0] first_diff,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StWarmup  = 2'd0,
    StCompare = 2'd1,
    StFail    = 2'd2
  } state_e;

  // WARMUP + SKEW never exceeds 270, so 9 bits suffice.
  localparam int unsigned WarmTotal = WARMUP + SKEW;

  logic [WIDTH-1:0] ya_dly;

  if (SKEW == 0) begin : g_no_dly
    assign ya_dly = y_a;
  end else begin : g_dly
    logic [WIDTH-1:0] dly_q [SKEW];
    logic [WIDTH-1:0] dly_d [SKEW];

    always_comb begin
      for (int i = 0; i < int'(SKEW); i++) begin
        dly_d[i] = dly_q[i];
      end
      if (en) begin
        dly_d[0] = y_a;
        for (int i = 1; i < int'(SKEW); i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < int'(SKEW); i++) begin
        if (!rst_n) begin
          dly_q[i] <= '0;
        end else begin
          dly_q[i] <= dly_d[i];
        end
      end
    end

    assign ya_dly = dly_q[SKEW-1];
  end

  state_e           state_q, state_d;
  logic [8:0]       warm_q, warm_d;
  logic [31:0]      idx_q, idx_d;
  logic             mismatch_q, mismatch_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      fidx_q, fidx_d;
  logic [WIDTH-1:0] fdiff_q, fdiff_d;

  logic [WIDTH-1:0] diff;
  logic             cand;
  logic [8:0]       warm_next;

  assign diff      = (ya_dly ^ y_b) & ~mask;
  assign cand      = en && (state_q == StCompare) && (|diff);
  assign warm_next = warm_q + 9'(en);

  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    idx_d      = idx_q + 32'(en);
    mismatch_d = 1'b0;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    fidx_d     = fidx_q;
    fdiff_d    = fdiff_q;

    unique case (state_q)
      StWarmup: begin
        warm_d = warm_next;
        // A zero-length window falls through to compare immediately.
        if (warm_next >= 9'(WarmTotal)) begin
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (cand && !clear && STOP_ON_FAIL) begin
          state_d = StFail;
        end
      end
      StFail: begin
        if (clear) begin
          state_d = StCompare;
        end
      end
      default: state_d = StWarmup;
    endcase

    // clear outranks a simultaneous candidate: it is dropped entirely.
    if (clear) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
      fidx_d   = '0;
      fdiff_d  = '0;
    end else if (cand) begin
      mismatch_d = 1'b1;
      sticky_d   = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (!sticky_q) begin
        fidx_d  = idx_q;
        fdiff_d = diff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StWarmup;
      warm_q     <= '0;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
      fidx_q     <= '0;
      fdiff_q    <= '0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      fidx_q     <= fidx_d;
      fdiff_q    <= fdiff_d;
    end
  end

  assign mismatch     = mismatch_q;
  assign sticky_err   = sticky_q;
  assign mismatch_cnt = cnt_q;
  assign first_idx    = fidx_q;
  assign first_diff   = fdiff_q;
  assign state        = state_q;

endmodule

// File: doc/equiv_monitor.md
EQUIV_MONITOR -- requirements
Module: equiv_monitor

Interface
REQ-001 Parameter WIDTH, default 91: compared bus width in bits.
REQ-002 Parameter SKEW, default 0, legal range 0..15: pipeline stages by which y_a is delayed to align with y_b.
REQ-003 Parameter WARMUP, default 4, legal range 0..255: enabled cycles ignored after reset, in addition to SKEW.
REQ-004 Parameter CNT_W, default 16: mismatch counter width.
REQ-005 Parameter STOP_ON_FAIL, default 0: 1 means the first mismatch freezes the monitor.
REQ-006 Port list (direction, width, meaning):
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- en, input, 1: sample-valid qualifier.
- clear, input, 1: clears statistics and recovers from FAIL.
- y_a, input, WIDTH: output of implementation A.
- y_b, input, WIDTH: output of implementation B.
- mask, input, WIDTH: bit=1 excludes that bit from comparison.
- mismatch, output, 1: one-cycle pulse per detected mismatch.
- sticky_err, output, 1: set on the first mismatch, held until clear or reset.
- mismatch_cnt, output, CNT_W: saturating mismatch count.
- first_idx, output, 32: sample index of the first mismatch.
- first_diff, output, WIDTH: masked XOR captured at the first mismatch.
- state, output, 2: 0=WARMUP, 1=COMPARE, 2=FAIL.

Function
REQ-007 Delay line: y_a passes through a SKEW-stage register chain that shifts only on en=1; SKEW=0 means no delay; y_b is not delayed.
REQ-008 Sample index: 32-bit counter incremented on every en=1 cycle from reset; it wraps at 2^32 and does not stop in any state.
REQ-009 Difference: diff = (delayed y_a XOR y_b) AND NOT mask; a mismatch candidate exists when en=1, state=COMPARE and diff is nonzero.
REQ-010 Latency: mismatch is registered and asserted exactly 1 cycle after the candidate cycle.
REQ-011 WARMUP state: entered on reset; count enabled cycles; move to COMPARE after WARMUP+SKEW enabled cycles; if WARMUP+SKEW=0, COMPARE starts on the first cycle after reset.
REQ-012 COMPARE state, on a candidate: increment mismatch_cnt, saturating at all-ones; set sticky_err.
REQ-013 First capture: if sticky_err was 0, load first_idx with the candidate's sample index and first_diff with diff; later mismatches do not update either capture.
REQ-014 STOP_ON_FAIL=1: the first candidate moves state to FAIL; in FAIL no comparisons occur, mismatch stays 0 and counter and captures are frozen.
REQ-015 STOP_ON_FAIL=0: state remains COMPARE after mismatches.
REQ-016 clear=1 actions:
- zero mismatch_cnt, sticky_err, first_idx and first_diff;
- FAIL moves to COMPARE;
- WARMUP and COMPARE are unchanged;
- sample index and delay line are not affected.
REQ-017 clear and candidate in the same cycle: clear wins; the candidate is discarded and no mismatch pulse is produced.
REQ-018 en=0: no candidate is generated, the warm-up count holds and the delay line holds.
REQ-019 mask changes apply combinationally to the cycle in which they are presented.

Reset
REQ-020 rst_n=0 sampled on a rising clk edge sets:
- state=WARMUP;
- mismatch=0, sticky_err=0;
- mismatch_cnt, first_idx and first_diff all 0;
- sample index and warm-up count 0;
- all delay-line stages 0.
REQ-021 rst_n asserted mid-operation overrides en and clear, and discards any pending mismatch pulse.

Verification
REQ-022 Defaults; y_a=y_b random for 100 cycles with en=1 -> state=1 after 4 cycles, mismatch never 1, mismatch_cnt=0.
REQ-023 Defaults; flip bit 7 of y_b at sample index 10 only -> mismatch pulses at index 11; sticky_err=1, mismatch_cnt=1, first_idx=10, first_diff=0x80.
REQ-024 SKEW=3; y_b equals y_a delayed 3 enabled cycles, with en toggled randomly -> no mismatch; a bit flip in y_b at index 4 (inside warm-up) is ignored.
REQ-025 STOP_ON_FAIL=1; mismatches at indices 20 and 25 -> state=2 from index 21; mismatch_cnt=1, first_idx=20; clear at index 30 gives state=1 and all statistics 0.
REQ-026 CNT_W=4; continuous mismatch for 20 enabled cycles -> mismatch_cnt saturates at 15; clear coinciding with a mismatch produces no pulse and cnt=0.
REQ-027 rst_n low for 1 cycle mid-run with sticky_err=1 -> all outputs return to reset values, and the warm-up sequence restarts.
